// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press, release, long-press and repeat events.
// Optional press counter output is enabled with `define BUTTON_EVENT_COUNT_EN.
module button_event_decoder #(
    parameter int COUNTER_WIDTH     = 16,
    parameter int PRESS_COUNT_WIDTH = 8
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic                         i_debounced_signal,
    input  logic [COUNTER_WIDTH-1:0]     i_long_press_count,
    input  logic [COUNTER_WIDTH-1:0]     i_repeat_count,
    output logic                         o_press,
    output logic                         o_release,
    output logic                         o_long_press,
    output logic                         o_repeat,
    output logic                         o_held,
    output logic [1:0]                   o_state
`ifdef BUTTON_EVENT_COUNT_EN
    ,
    output logic [PRESS_COUNT_WIDTH-1:0] o_press_count
`endif
);

    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic [COUNTER_WIDTH-1:0] count_inc;
    logic                     press_q, press_d;
    logic                     release_q, release_d;
    logic                     long_q, long_d;
    logic                     repeat_q, repeat_d;
    logic                     held_q, held_d;

    // The hold counter saturates so a very long hold can never re-trigger by wrapping.
    always_comb begin
        count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        held_d    = held_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (i_debounced_signal) begin
                    press_d = 1'b1;
                    count_d = CNT_ONE;
                    held_d  = 1'b1;
                    state_d = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (!i_debounced_signal) begin
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    count_d   = '0;
                    state_d   = ST_RELEASED;
                end else if ((i_long_press_count != '0) && (count_q >= i_long_press_count)) begin
                    long_d  = 1'b1;
                    count_d = CNT_ONE;
                    state_d = ST_LONG_HELD;
                end else begin
                    count_d = count_inc;
                end
            end
            ST_LONG_HELD: begin
                if (!i_debounced_signal) begin
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    count_d   = '0;
                    state_d   = ST_RELEASED;
                end else if ((i_repeat_count != '0) && (count_q >= i_repeat_count)) begin
                    repeat_d = 1'b1;
                    count_d  = CNT_ONE;
                end else begin
                    count_d = count_inc;
                end
            end
            default: begin
                held_d  = 1'b0;
                count_d = '0;
                state_d = ST_RELEASED;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_RELEASED;
            count_q   <= '0;
            held_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign o_press      = press_q;
    assign o_release    = release_q;
    assign o_long_press = long_q;
    assign o_repeat     = repeat_q;
    assign o_held       = held_q;
    assign o_state      = state_q;

`ifdef BUTTON_EVENT_COUNT_EN
    logic [PRESS_COUNT_WIDTH-1:0] press_count_q, press_count_d;

    // Counts alongside the press pulse so the new total is visible while o_press is high.
    always_comb begin
        press_count_d = press_count_q;
        if (press_d) begin
            press_count_d = press_count_q + PRESS_COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            press_count_q <= '0;
        end else begin
            press_count_q <= press_count_d;
        end
    end

    assign o_press_count = press_count_q;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder built with COUNTER_WIDTH=4 and PRESS_COUNT_WIDTH=2.
// Event vector compared each cycle is {press, release, long_press, repeat, held}.
module tb_button_event_decoder;

    localparam int CW  = 4;
    localparam int PCW = 2;

    logic          clk;
    logic          rst_n;
    logic          din;
    logic [CW-1:0] long_n;
    logic [CW-1:0] rep_n;
    logic          o_press;
    logic          o_release;
    logic          o_long_press;
    logic          o_repeat;
    logic          o_held;
    logic [1:0]    o_state;
`ifdef BUTTON_EVENT_COUNT_EN
    logic [PCW-1:0] o_press_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [4:0] obs;
    logic [4:0] exp_v;

    button_event_decoder #(
        .COUNTER_WIDTH     (CW),
        .PRESS_COUNT_WIDTH (PCW)
    ) dut (
        .i_clock            (clk),
        .i_reset_n          (rst_n),
        .i_debounced_signal (din),
        .i_long_press_count (long_n),
        .i_repeat_count     (rep_n),
        .o_press            (o_press),
        .o_release          (o_release),
        .o_long_press       (o_long_press),
        .o_repeat           (o_repeat),
        .o_held             (o_held),
        .o_state            (o_state)
`ifdef BUTTON_EVENT_COUNT_EN
        ,
        .o_press_count      (o_press_count)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver: present a level for the next rising edge, then settle past it
    task automatic step(input logic level);
        din = level;
        @(posedge clk);
        #1;
        obs = {o_press, o_release, o_long_press, o_repeat, o_held};
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        din    = 1'b1;
        long_n = '0;
        rep_n  = '0;
        repeat (3) @(posedge clk);
        #1;
        obs = {o_press, o_release, o_long_press, o_repeat, o_held};
        checks++;
        if (obs !== 5'b00000 || o_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_values obs=%b state=%0d exp=00000 state=0", obs, o_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1);
        checks++;
        if (obs !== 5'b10001) begin
            failures++;
            $display("FAIL reset_first_press obs=%b exp=10001", obs);
        end
        step(1'b1);
        checks++;
        if (obs !== 5'b00001) begin
            failures++;
            $display("FAIL reset_press_width obs=%b exp=00001", obs);
        end
        step(1'b0);
        checks++;
        if (obs !== 5'b01000) begin
            failures++;
            $display("FAIL reset_release obs=%b exp=01000", obs);
        end
        step(1'b0);
        checks++;
        if (obs !== 5'b00000) begin
            failures++;
            $display("FAIL reset_idle obs=%b exp=00000", obs);
        end
    endtask

    task automatic test_long_press();
        long_n = 4'd10;
        rep_n  = 4'd0;
        for (int e = 0; e < 32; e++) begin
            step(e < 30);
            exp_v = {e == 0, e == 30, e == 10, 1'b0, e < 30};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL long_press e=%0d obs=%b exp=%b", e, obs, exp_v);
            end
        end
    endtask

    task automatic test_repeat();
        long_n = 4'd4;
        rep_n  = 4'd3;
        for (int e = 0; e < 22; e++) begin
            step(e < 20);
            exp_v = {e == 0, e == 20, e == 4, (e >= 7 && e <= 19 && ((e - 7) % 3) == 0), e < 20};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL repeat e=%0d obs=%b exp=%b", e, obs, exp_v);
            end
        end
    endtask

    task automatic test_release_priority();
        long_n = 4'd5;
        rep_n  = 4'd0;
        for (int e = 0; e < 7; e++) begin
            step(e < 5);
            exp_v = {e == 0, e == 5, 1'b0, 1'b0, e < 5};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL release_priority e=%0d obs=%b exp=%b", e, obs, exp_v);
            end
        end
    endtask

    task automatic test_saturate();
        long_n = 4'd0;
        rep_n  = 4'd1;
        for (int e = 0; e < 23; e++) begin
            step(e < 21);
            exp_v = {e == 0, e == 21, 1'b0, 1'b0, e < 21};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL saturate_disabled e=%0d obs=%b exp=%b", e, obs, exp_v);
            end
        end
        // a saturated counter meets the maximum threshold on the very next edge
        rep_n = 4'd0;
        for (int e = 0; e < 24; e++) begin
            long_n = (e >= 20) ? 4'd15 : 4'd0;
            step(e < 22);
            exp_v = {e == 0, e == 22, e == 20, 1'b0, e < 22};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL saturate_probe e=%0d obs=%b exp=%b", e, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        long_n = 4'd4;
        rep_n  = 4'd2;
        for (int e = 0; e < 6; e++) begin
            step(e == 0 || e == 2);
            exp_v = {e == 0 || e == 2, e == 1 || e == 3, 1'b0, 1'b0, e == 0 || e == 2};
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL back_to_back e=%0d obs=%b exp=%b", e, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        long_n = 4'd2;
        rep_n  = 4'd0;
        for (int e = 0; e < 5; e++) begin
            step(1'b1);
        end
        checks++;
        if (obs !== 5'b00001 || o_state !== 2'd2) begin
            failures++;
            $display("FAIL mid_hold_before obs=%b state=%0d exp=00001 state=2", obs, o_state);
        end
        #2;
        rst_n = 1'b0;
        #1;
        obs = {o_press, o_release, o_long_press, o_repeat, o_held};
        checks++;
        if (obs !== 5'b00000 || o_state !== 2'd0) begin
            failures++;
            $display("FAIL mid_hold_async obs=%b state=%0d exp=00000 state=0", obs, o_state);
        end
`ifdef BUTTON_EVENT_COUNT_EN
        checks++;
        if (o_press_count !== 2'd0) begin
            failures++;
            $display("FAIL mid_hold_count obs=%0d exp=0", o_press_count);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1);
        checks++;
        if (obs !== 5'b10001) begin
            failures++;
            $display("FAIL mid_hold_repress obs=%b exp=10001", obs);
        end
        step(1'b0);
        step(1'b0);
    endtask

`ifdef BUTTON_EVENT_COUNT_EN
    task automatic test_press_count();
        logic [PCW-1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step(1'b0);
        for (int p = 0; p < 5; p++) begin
            step(1'b1);
            step(1'b0);
            step(1'b0);
            checks++;
            if (o_press_count !== exp_cnt[p]) begin
                failures++;
                $display("FAIL press_count p=%0d obs=%0d exp=%0d", p, o_press_count, exp_cnt[p]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_long_press();
        test_repeat();
        test_release_priority();
        test_saturate();
        test_back_to_back();
        test_reset_mid_hold();
`ifdef BUTTON_EVENT_COUNT_EN
        test_press_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the clean level from the debouncer, in the same clock domain, and turns it into single-cycle events for control logic: press, release, long-press and auto-repeat.
- It is the consumer end of the debounced-button interface. It sits between the debouncer and any SPI command or test-pattern control logic.
- Thresholds are runtime inputs, matching the debouncer's runtime counter input.

Parameters:
- COUNTER_WIDTH, 16: width of the hold counter and of both threshold inputs.
- PRESS_COUNT_WIDTH, 8: width of o_press_count (used only with the optional feature).

Ports:
- i_clock  in  1  system clock; all logic on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_debounced_signal  in  1  clean button level, 1 = pressed; synchronous to i_clock.
- i_long_press_count  in  COUNTER_WIDTH  cycles from press to long-press event; 0 = long-press disabled.
- i_repeat_count  in  COUNTER_WIDTH  cycles between repeat events after long-press; 0 = repeat disabled.
- o_press  out  1  one-cycle pulse on press.
- o_release  out  1  one-cycle pulse on release.
- o_long_press  out  1  one-cycle pulse when the hold reaches i_long_press_count.
- o_repeat  out  1  one-cycle pulse every i_repeat_count cycles while long-held.
- o_held  out  1  level, 1 while the FSM is outside RELEASED.
- o_press_count  out  PRESS_COUNT_WIDTH  presses seen (only with BUTTON_EVENT_COUNT_EN).

Behaviour:
- Reset (async assert, sync deassert by upstream reset logic):
  - State RELEASED, hold counter 0.
  - All outputs 0, including o_press_count.
  - Reset mid-hold drops all outputs immediately.
  - After reset, a button that is already pressed gives o_press on the first active cycle; no release event is generated for the interrupted hold.
- All outputs are registered. Pulses are exactly one cycle wide, and at most one pulse is asserted per cycle.
- FSM states: RELEASED, PRESSED, LONG_HELD (2-bit enum).
- RELEASED:
  - On the edge sampling i_debounced_signal=1: o_press=1 for the following cycle, counter<=1, o_held<=1, go to PRESSED.
- PRESSED:
  - If input=0: o_release pulse, o_held<=0, counter<=0, go to RELEASED.
  - Else if i_long_press_count!=0 and counter>=i_long_press_count: o_long_press pulse, counter<=1, go to LONG_HELD.
  - Else counter<=counter+1, saturating at all-ones.
- LONG_HELD:
  - If input=0: o_release pulse, go to RELEASED, counter<=0.
  - Else if i_repeat_count!=0 and counter>=i_repeat_count: o_repeat pulse, counter<=1.
  - Else counter<=counter+1, saturating.
- Priority: release beats long-press or repeat in the same cycle; no event is emitted on the release cycle other than o_release.
- Latency from the input rise being sampled at edge k:
  - o_press is high during cycle k.
  - o_long_press rises exactly N cycles after o_press rises (N=i_long_press_count).
  - Successive o_repeat pulses are R cycles apart, the first R cycles after o_long_press.
- Comparison is >=, so lowering a threshold mid-hold fires on the next cycle rather than waiting for wrap. The counter never wraps.
- A one-cycle press (high for a single sample) still gives o_press followed by o_release on the next cycle.
- Threshold changes take effect on the next comparison; no internal latching.

Optional Feature:
- Macro: BUTTON_EVENT_COUNT_EN.
- Defined:
  - o_press_count exists; it increments by 1 on every cycle o_press is asserted.
  - It wraps modulo 2^PRESS_COUNT_WIDTH and clears only on reset.
- Not defined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset with input=1, then release reset -> o_press high on the 1st active cycle, o_held=1; drop input -> o_release one cycle later, o_held=0.
- N=10, R=0, hold 30 cycles -> o_press at t0, o_long_press at t0+10, no o_repeat, o_release after the input falls.
- N=4, R=3, hold 20 cycles -> o_long_press at t0+4; o_repeat at t0+7, +10, +13, +16, +19; every pulse exactly one cycle wide.
- N=5, input falls on the cycle the counter reaches 5 -> o_release only, no o_long_press.
- N=0 (long-press disabled), hold 2^COUNTER_WIDTH+5 cycles with COUNTER_WIDTH=4 -> no long/repeat events, counter saturates at 15, release still reported.
- With BUTTON_EVENT_COUNT_EN and PRESS_COUNT_WIDTH=2: 5 short presses -> o_press_count=1,2,3,0,1; assert i_reset_n=0 mid-hold -> all outputs 0 asynchronously.
